// File: rtl/sdram_model_pkg.sv
// Shared types and default timing for the behavioural word SDRAM model.
package sdram_model_pkg;

    // Controller state: waiting for a request, or counting down an operation.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Operation latched at acceptance time.
    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_REF = 2'd2
    } op_t;

    // Default geometry and busy latencies (in clock cycles).
    localparam int DEF_MEM_SIZE = 1048576;
    localparam int DEF_RD_LAT   = 4;
    localparam int DEF_WR_LAT   = 4;
    localparam int DEF_REF_LAT  = 8;

    // Width of the busy countdown; comfortably covers any sane latency.
    localparam int CNT_W = 16;

    // Countdown start value for an operation: the stall flag is high for
    // LAT cycles, and the completing edge is the one that sees zero.
    function automatic logic [CNT_W-1:0] lat_load(input op_t op,
                                                  input int  rd_lat,
                                                  input int  wr_lat,
                                                  input int  ref_lat);
        int lat;
        case (op)
            OP_RD:   lat = rd_lat;
            OP_WR:   lat = wr_lat;
            default: lat = ref_lat;
        endcase
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/sdram_word_model.sv
// Behavioural 32-bit word SDRAM behind a busy/strobe handshake.
//
// Handshake: the master raises exactly one of w_we / w_le / w_refresh (or
// several; write beats read beats refresh) and holds it until it sees
// w_stall high. A request is accepted on the first rising edge at which the
// model is idle; w_stall then stays high for exactly the operation latency,
// during which every request input is ignored. Read data is valid on w_odata
// from the first cycle w_stall is low again and is held until the next read
// completes. A request present in that first low cycle is accepted at the
// next edge, so back-to-back operations need no idle gap.
//
// The byte array `mem` is kept in this module so benches can reach it
// hierarchically. Its contents are never touched by reset.
module sdram_word_model
    import sdram_model_pkg::*;
#(
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int WR_LAT   = DEF_WR_LAT,
    parameter int REF_LAT  = DEF_REF_LAT
) (
    input  logic        CLK,
    input  logic        rst_x,
    input  logic [31:0] w_addr,
    input  logic        w_le,
    input  logic        w_we,
    input  logic        w_refresh,
    input  logic [31:0] w_wdata,
    input  logic [3:0]  w_mask,
    output logic [31:0] w_odata,
    output logic        w_stall,
    input  logic [31:0] w_mtime
);

    // Byte address width; addresses wrap modulo MEM_SIZE by truncation.
    localparam int AW = $clog2(MEM_SIZE);

    logic [7:0] mem [0:MEM_SIZE-1];

    // Operation registers, loaded when a request is accepted.
    state_t           state;
    op_t              op_q;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       mask_q;
    logic [CNT_W-1:0] cnt;

    // Request decode.
    logic             req_any;
    op_t              req_op;
    logic [AW-1:0]    req_addr;

    // Completion strobe and word assembled from the latched address.
    logic             finish;
    logic [AW-1:0]    byte_idx [4];
    logic [31:0]      rd_word;

    // Priority-encode the requests and force the address word-aligned.
    always_comb begin
        req_any  = w_we | w_le | w_refresh;
        req_op   = OP_REF;
        if (w_we) begin
            req_op = OP_WR;
        end else if (w_le) begin
            req_op = OP_RD;
        end
        req_addr = w_addr[AW-1:0] & ~AW'(3);
    end

    // Byte lanes of the latched word, little-endian, and the completion edge.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_idx[k] = addr_q | AW'(k);
        end
        rd_word = {mem[byte_idx[3]], mem[byte_idx[2]],
                   mem[byte_idx[1]], mem[byte_idx[0]]};
        finish  = (state == BUSY) && (cnt == '0);
    end

    // Control FSM: accept in IDLE, count down in BUSY, complete on zero.
    always_ff @(posedge CLK or negedge rst_x) begin
        if (!rst_x) begin
            state   <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            cnt     <= '0;
            w_stall <= 1'b0;
            w_odata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= w_wdata;
                        mask_q  <= w_mask;
                        cnt     <= lat_load(req_op, RD_LAT, WR_LAT, REF_LAT);
                        w_stall <= 1'b1;
                        state   <= BUSY;
                    end else begin
                        w_stall <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (op_q == OP_RD) begin
                            w_odata <= rd_word;
                        end
                        w_stall <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    w_stall <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: masked byte writes land on the completing edge only.
    // A reset mid-operation returns the FSM to IDLE, so no write follows.
    always_ff @(posedge CLK) begin
        if (finish && (op_q == OP_WR)) begin
            for (int k = 0; k < 4; k++) begin
                if (mask_q[k]) begin
                    mem[byte_idx[k]] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    // The timestamp only feeds debug messages, and the address bits above
    // the array size and below word granularity carry no function here.
    logic unused_bits;
    assign unused_bits = &{1'b0, w_mtime, w_addr[31:AW], w_addr[1:0]};

endmodule

// File: tb/tb_sdram_word_model.sv
// Directed plus randomized bench for sdram_word_model with a byte-level
// reference memory and a simple timing model (busy = latency per op type).
module tb_sdram_word_model;

    localparam int MEM_SIZE = 1048576;
    localparam int RD_LAT   = 4;
    localparam int WR_LAT   = 4;
    localparam int REF_LAT  = 8;

    logic        CLK = 1'b0;
    logic        rst_x;
    logic [31:0] w_addr;
    logic        w_le;
    logic        w_we;
    logic        w_refresh;
    logic [31:0] w_wdata;
    logic [3:0]  w_mask;
    logic [31:0] w_odata;
    logic        w_stall;
    logic [31:0] w_mtime = '0;

    int errors = 0;
    int checks = 0;

    // Reference state: sparse byte memory and the last read result.
    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] ref_odata;

    sdram_word_model #(
        .MEM_SIZE (MEM_SIZE),
        .RD_LAT   (RD_LAT),
        .WR_LAT   (WR_LAT),
        .REF_LAT  (REF_LAT)
    ) dut (
        .CLK       (CLK),
        .rst_x     (rst_x),
        .w_addr    (w_addr),
        .w_le      (w_le),
        .w_we      (w_we),
        .w_refresh (w_refresh),
        .w_wdata   (w_wdata),
        .w_mask    (w_mask),
        .w_odata   (w_odata),
        .w_stall   (w_stall),
        .w_mtime   (w_mtime)
    );

    // Clock and timestamp.
    always #5 CLK = ~CLK;
    always @(posedge CLK) w_mtime <= w_mtime + 1;

    // Watchdog in case the sequence itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned word_base(input logic [31:0] a);
        return (a & (MEM_SIZE - 1)) & ~32'd3;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        int unsigned b;
        b = word_base(a);
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (ref_mem.exists(b + k)) w[8*k +: 8] = ref_mem[b + k];
        end
        return w;
    endfunction

    function automatic logic [31:0] dut_word(input logic [31:0] a);
        int unsigned b;
        b = word_base(a);
        return {dut.mem[b + 3], dut.mem[b + 2], dut.mem[b + 1], dut.mem[b]};
    endfunction

    // Master driver: raise the request, hold it `hold` extra busy cycles
    // after stall is seen, then wait for stall to fall. Entered and left on
    // a falling edge. Checks busy length and read data against the model.
    task automatic run_op(input bit we, input bit le, input bit rf,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input int hold, input string tag);
        int busy;
        int exp_busy;
        int hold_left;
        bit seen;
        bit done;
        w_we = we; w_le = le; w_refresh = rf;
        w_addr = addr; w_wdata = data; w_mask = mask;
        busy = 0; seen = 0; done = 0; hold_left = hold;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (w_stall) begin
                busy++;
                seen = 1'b1;
                if (hold_left == 0) begin
                    w_we = 1'b0; w_le = 1'b0; w_refresh = 1'b0;
                end else begin
                    hold_left--;
                end
            end else if (seen) begin
                done = 1'b1;
            end
        end
        w_we = 1'b0; w_le = 1'b0; w_refresh = 1'b0;

        // Reference behaviour: write beats read beats refresh.
        if (we) begin
            exp_busy = WR_LAT;
            for (int k = 0; k < 4; k++)
                if (mask[k]) ref_mem[word_base(addr) + k] = data[8*k +: 8];
        end else if (le) begin
            exp_busy = RD_LAT;
            ref_odata = ref_word(addr);
        end else begin
            exp_busy = REF_LAT;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, busy, exp_busy);
        check({tag, "_odata"}, w_odata, ref_odata);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input string tag);
        run_op(1'b1, 1'b0, 1'b0, a, d, m, 0, tag);
    endtask

    task automatic rd(input logic [31:0] a, input int hold, input string tag);
        run_op(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, hold, tag);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] saved;

        rst_x = 1'b0; w_addr = '0; w_le = 1'b0; w_we = 1'b0; w_refresh = 1'b0;
        w_wdata = '0; w_mask = '0; ref_odata = '0;

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_stall", 32'(w_stall), 32'd0);
        check("rst_odata", w_odata, 32'd0);
        rst_x = 1'b1;
        @(negedge CLK);

        // Full write, byte placement, read-back.
        wr(32'h10, 32'hDEADBEEF, 4'b1111, "full_wr");
        check("full_b0", 32'(dut.mem[32'h10]), 32'hEF);
        check("full_b1", 32'(dut.mem[32'h11]), 32'hBE);
        check("full_b2", 32'(dut.mem[32'h12]), 32'hAD);
        check("full_b3", 32'(dut.mem[32'h13]), 32'hDE);
        rd(32'h10, 0, "full_rd");
        check("full_rd_val", w_odata, 32'hDEADBEEF);

        // Byte-masked write.
        wr(32'h20, 32'h11223344, 4'b1111, "mask_pre");
        wr(32'h20, 32'hAABBCCDD, 4'b0110, "mask_wr");
        rd(32'h20, 0, "mask_rd");
        check("mask_rd_val", w_odata, 32'h11BBCC44);

        // Held read request: one busy period only.
        rd(32'h10, 1, "held_rd");
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); @(negedge CLK);
            check("held_no_rebusy", 32'(w_stall), 32'd0);
        end

        // Refresh leaves memory and read data alone.
        wr(32'h40, 32'h12345678, 4'b1111, "ref_pre");
        rd(32'h10, 0, "ref_prior_rd");
        run_op(1'b0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, "refresh");
        check("ref_odata_held", w_odata, 32'hDEADBEEF);
        check("ref_mem_kept", dut_word(32'h40), 32'h12345678);
        rd(32'h40, 0, "ref_rd");

        // Write wins over a simultaneous read.
        d = $urandom;
        saved = w_odata;
        run_op(1'b1, 1'b1, 1'b0, 32'h50, d, 4'hF, 0, "prio");
        check("prio_odata_kept", w_odata, saved);
        check("prio_mem", dut_word(32'h50), d);
        rd(32'h50, 0, "prio_rd");

        // Address wrap and ignored low address bits.
        d = $urandom;
        wr(MEM_SIZE + 8, d, 4'hF, "wrap_wr");
        check("wrap_mem", dut_word(32'h8), ref_word(32'h8));
        rd(32'h8, 0, "wrap_rd");
        rd(32'h13, 0, "misalign_rd");
        rd(MEM_SIZE - 4 + MEM_SIZE, 0, "last_alias_rd");

        // Mask 0000 is a full-latency no-op.
        wr(32'h10, 32'h0, 4'b0000, "mask0_wr");
        check("mask0_mem", dut_word(32'h10), 32'hDEADBEEF);

        // Randomized back-to-back traffic over a small window.
        for (int i = 0; i < 16; i++)
            wr(32'h100 + 4 * i, $urandom, 4'hF, "rnd_fill");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 2);
            a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            run_op(kind == 0, kind == 1, kind == 2, a, $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 2), "rnd");
        end
        for (int i = 0; i < 16; i++)
            check("rnd_mem", dut_word(32'h100 + 4 * i), ref_word(32'h100 + 4 * i));

        // Reset during the second busy cycle of a write.
        wr(32'h60, 32'h0BADF00D, 4'hF, "rst_pre");
        w_we = 1'b1; w_addr = 32'h60; w_wdata = 32'hCAFEF00D; w_mask = 4'hF;
        @(posedge CLK); @(negedge CLK);
        check("rst_mid_busy1", 32'(w_stall), 32'd1);
        w_we = 1'b0;
        @(posedge CLK);
        #2 rst_x = 1'b0;
        #1;
        check("rst_mid_stall", 32'(w_stall), 32'd0);
        check("rst_mid_odata", w_odata, 32'd0);
        ref_odata = '0;
        repeat (2) @(negedge CLK);
        rst_x = 1'b1;
        repeat (6) @(negedge CLK);
        check("rst_mid_idle", 32'(w_stall), 32'd0);
        check("rst_mid_mem", dut_word(32'h60), 32'h0BADF00D);
        rd(32'h60, 0, "rst_after_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_word_model.md
Name: sdram_word_model

Overview:
- Behavioural, simulation-only model of a 32-bit word SDRAM behind a busy/strobe handshake.
- Stands in for the board memory controller under the DRAM_conRV memory adapter when simulating.
- Models a byte-addressed, little-endian memory array with per-byte write enables, fixed per-operation busy latencies, and a no-op refresh command.
- Testbenches preload the array through a hierarchical reference to the byte array `mem`.

Parameters:
- MEM_SIZE, 1048576: memory size in bytes; must be a power of two and at least 4.
- RD_LAT, 4: number of cycles `w_stall` stays high for a read; must be at least 1.
- WR_LAT, 4: number of cycles `w_stall` stays high for a write; must be at least 1.
- REF_LAT, 8: number of cycles `w_stall` stays high for a refresh; must be at least 1.

Ports:
- CLK  input  1  system clock; everything samples on the rising edge.
- rst_x  input  1  asynchronous, active-low reset.
- w_addr  input  32  byte address. Bits [1:0] are ignored (forced word-aligned). The address wraps modulo MEM_SIZE.
- w_le  input  1  read request, level-sensitive.
- w_we  input  1  write request, level-sensitive.
- w_refresh  input  1  refresh request, level-sensitive.
- w_wdata  input  32  write data; byte k is w_wdata[8k+7:8k].
- w_mask  input  4  active-high byte write enables; bit k enables byte k.
- w_odata  output  32  read data; registered and held between reads.
- w_stall  output  1  busy flag; registered.
- w_mtime  input  32  timestamp used only in debug messages; no functional effect.

Behaviour:
- Storage: byte array `mem[0:MEM_SIZE-1]`.
  - Word at byte address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}, where A = {w_addr[31:2], 2'b00} mod MEM_SIZE.
  - Contents are never cleared by reset.
- Reset (asynchronous, rst_x=0):
  - w_stall=0, w_odata=0, state=IDLE, counter=0.
  - Any operation in flight is aborted; a pending write is discarded.
- State machine: IDLE, BUSY.
- IDLE: at each rising edge, sample the requests with priority w_we > w_le > w_refresh.
  - If a request is taken, latch the operation type, the word address, w_wdata and w_mask.
  - Then set w_stall=1, load counter = LAT-1 for that operation, and go to BUSY.
  - With no request, stay in IDLE with w_stall=0.
- BUSY:
  - All request inputs are ignored, including a request still held high from the accept cycle.
  - Each edge with counter>0 decrements counter.
  - On the edge where counter==0:
    - write: for each k with mask[k]=1, mem[A+k] <= wdata byte k; bytes with mask[k]=0 are unchanged.
    - read: w_odata <= word at A.
    - refresh: no memory or w_odata change.
  - Same edge: w_stall<=0 and return to IDLE.
- Latency: w_stall is high for exactly RD_LAT / WR_LAT / REF_LAT cycles, starting the cycle after acceptance.
  - Read data is valid on w_odata in the first cycle w_stall is low again.
  - w_odata stays stable until the next read completes.
- Master handshake supported:
  - Master holds the request until it sees w_stall=1, then drops it.
  - Master waits for w_stall=0, then uses the data.
- Back-to-back: a request present in the cycle w_stall returns low is accepted at the next edge. Minimum gap is 0 idle cycles.
- Mask 4'b0000 on a write: a full-latency no-op.
- Address wrap: A = MEM_SIZE-4 is the last valid word; MEM_SIZE aliases to word 0.
- Simulation: optionally $display an error with w_mtime if w_addr[1:0]!=0 on an accepted read or write.

Decomposition:
- Shared package `sdram_model_pkg`:
  - state enum (IDLE, BUSY);
  - operation enum (OP_RD, OP_WR, OP_REF);
  - default latency constants.
- No sub-module; the byte array lives directly in this module so hierarchical preloading of `mem` keeps working.

Test Plan:
- Reset then full write: rst_x low then high; write A=0x10, data 0xDEADBEEF, mask 4'b1111. Expect w_stall high for exactly 4 cycles, then mem[0x10..0x13] = EF, BE, AD, DE. A following read of 0x10 gives w_odata = 0xDEADBEEF in the cycle after w_stall falls.
- Byte-masked write: preload word 0x20 = 0x11223344; write data 0xAABBCCDD with mask 4'b0110. A subsequent read returns 0x11BBCC44.
- Held request: hold w_le high for 1 cycle after w_stall rises. Expect exactly one read, busy for 4 cycles, and no second busy period.
- Refresh: preload word 0x40 = 0x12345678; hold w_odata at a prior value; assert w_refresh. Expect busy for 8 cycles, then w_odata and memory unchanged. A read of 0x40 then returns 0x12345678.
- Priority and wrap: w_we and w_le asserted together. Expect the write to be taken first. A write to address MEM_SIZE+8 lands at word 8.
- Reset mid-write: assert rst_x low during the 2nd busy cycle of a write. Expect w_stall=0 immediately and target memory unchanged.
